ubus_slave_memory: RTL and testbench

//  UBUS memory slave; consumes the transfers sequenced by the bus arbiter/controller.

---
 rtl/ubus_pkg.sv | 12 +
 rtl/ubus_slave_mem_array.sv | 25 ++
 rtl/ubus_slave_memory.sv | 149 ++++++++++++++
 tb/tb_ubus_slave_memory.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ubus_pkg.sv
// Shared UBUS slave types: transfer size encoding, slave FSM states and size decode.
package ubus_pkg;

    typedef enum logic [1:0] {SZ1, SZ2, SZ4, SZ8} ubus_size_e;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} slave_state_e;

    function automatic logic [3:0] size_to_beats(input ubus_size_e sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/ubus_slave_mem_array.sv
// Byte-wide local RAM: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module ubus_slave_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ubus_slave_memory.sv
// UBUS memory slave: decodes the address phase after ubus_start, then runs data beats with
// WAIT_STATES wait cycles each; wait/error/data are registered and tri-stated when not selected.
module ubus_slave_memory
    import ubus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic        ubus_clock,
    input  logic        ubus_reset,
    input  logic        ubus_start,
    input  logic [15:0] ubus_addr,
    input  logic [1:0]  ubus_size,
    input  logic        ubus_read,
    input  logic        ubus_write,
    input  logic        ubus_bip,
    inout  wire  [7:0]  ubus_data,
    output logic        ubus_wait,
    output logic        ubus_error
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [16:0] WIN_HI = WIN_LO + 17'(DEPTH - 1);
    localparam logic [2:0]  WS     = 3'(WAIT_STATES);
    localparam logic        FIRST_WAIT = (WAIT_STATES != 0);

    slave_state_e  state_q;
    logic          sel_q;
    logic          wait_q;
    logic          error_q;
    logic          drv_q;
    logic          rd_q;
    logic [AW-1:0] offset_q;
    logic [2:0]    wcnt_q;
    logic [3:0]    beat_q;
    logic [3:0]    beats_q;

    logic [3:0]    req_beats;
    logic [16:0]   addr_ext;
    logic [16:0]   last_ext;
    logic          in_win;
    logic          req;
    logic          we;
    logic [7:0]    rdata;

    assign req_beats = size_to_beats(ubus_size_e'(ubus_size));
    assign addr_ext  = {1'b0, ubus_addr};
    assign last_ext  = addr_ext + {13'd0, req_beats} - 17'd1;
    assign in_win    = (addr_ext >= WIN_LO) && (addr_ext <= WIN_HI);
    assign req       = ubus_read | ubus_write;

    always_ff @(posedge ubus_clock or posedge ubus_reset) begin
        if (ubus_reset) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            wait_q   <= 1'b0;
            error_q  <= 1'b0;
            drv_q    <= 1'b0;
            rd_q     <= 1'b0;
            offset_q <= '0;
            wcnt_q   <= '0;
            beat_q   <= '0;
            beats_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ubus_start) begin
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (!req || !in_win) begin
                        state_q <= IDLE;
                    end else if (last_ext > WIN_HI) begin
                        state_q <= ERR;
                        sel_q   <= 1'b1;
                        error_q <= 1'b1;
                        wait_q  <= 1'b0;
                        drv_q   <= 1'b0;
                    end else begin
                        state_q  <= DATA;
                        sel_q    <= 1'b1;
                        error_q  <= 1'b0;
                        rd_q     <= ubus_read;
                        offset_q <= AW'(ubus_addr - BASE_ADDR);
                        wcnt_q   <= WS;
                        wait_q   <= FIRST_WAIT;
                        drv_q    <= ubus_read && !FIRST_WAIT;
                        beat_q   <= '0;
                        beats_q  <= req_beats;
                    end
                end
                DATA: begin
                    if (wait_q) begin
                        // wait drops in the same edge that takes the counter to zero
                        wcnt_q <= wcnt_q - 3'd1;
                        if (wcnt_q == 3'd1) begin
                            wait_q <= 1'b0;
                            drv_q  <= rd_q;
                        end
                    end else if (!ubus_bip) begin
                        state_q <= IDLE;
                        sel_q   <= 1'b0;
                        drv_q   <= 1'b0;
                    end else if (beat_q + 4'd1 >= beats_q) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                        drv_q   <= 1'b0;
                    end else begin
                        offset_q <= offset_q + 1'b1;
                        beat_q   <= beat_q + 4'd1;
                        wcnt_q   <= WS;
                        wait_q   <= FIRST_WAIT;
                        drv_q    <= rd_q && !FIRST_WAIT;
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                    sel_q   <= 1'b0;
                    error_q <= 1'b0;
                    wait_q  <= 1'b0;
                    drv_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign we = (state_q == DATA) && !wait_q && !rd_q;

    ubus_slave_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (ubus_clock),
        .we    (we),
        .waddr (offset_q),
        .wdata (ubus_data),
        .raddr (offset_q),
        .rdata (rdata)
    );

    assign ubus_data  = drv_q ? rdata : 8'bz;
    assign ubus_wait  = sel_q ? wait_q : 1'bz;
    assign ubus_error = sel_q ? error_q : 1'bz;

endmodule

// File: tb/tb_ubus_slave_memory.sv
// Bench for ubus_slave_memory: each configuration is instantiated twice, once on pulled-up and
// once on pulled-down nets, so a released (Z) output is seen as the two copies disagreeing.
module tb_ubus_slave_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic        bip = 1'b0;
    logic        tb_drv = 1'b0;
    logic        tgt = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [1:0]  size = 2'd0;
    logic [7:0]  tb_dat = 8'h0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mdl [2][256];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    wire st0 = start & ~tgt;
    wire st1 = start & tgt;

    tri1       w_a0, e_a0, w_a1, e_a1;
    tri0       w_b0, e_b0, w_b1, e_b1;
    tri1 [7:0] d_a0, d_a1;
    tri0 [7:0] d_b0, d_b1;

    assign d_a0 = tb_drv ? tb_dat : 8'bz;
    assign d_b0 = tb_drv ? tb_dat : 8'bz;
    assign d_a1 = tb_drv ? tb_dat : 8'bz;
    assign d_b1 = tb_drv ? tb_dat : 8'bz;

    ubus_slave_memory #(.BASE_ADDR(16'h0100), .DEPTH(256), .WAIT_STATES(0)) u_a0 (
        .ubus_clock(clk), .ubus_reset(rst), .ubus_start(st0), .ubus_addr(addr),
        .ubus_size(size), .ubus_read(bus_rd), .ubus_write(bus_wr), .ubus_bip(bip),
        .ubus_data(d_a0), .ubus_wait(w_a0), .ubus_error(e_a0));
    ubus_slave_memory #(.BASE_ADDR(16'h0100), .DEPTH(256), .WAIT_STATES(0)) u_b0 (
        .ubus_clock(clk), .ubus_reset(rst), .ubus_start(st0), .ubus_addr(addr),
        .ubus_size(size), .ubus_read(bus_rd), .ubus_write(bus_wr), .ubus_bip(bip),
        .ubus_data(d_b0), .ubus_wait(w_b0), .ubus_error(e_b0));
    ubus_slave_memory #(.BASE_ADDR(16'h0100), .DEPTH(256), .WAIT_STATES(2)) u_a1 (
        .ubus_clock(clk), .ubus_reset(rst), .ubus_start(st1), .ubus_addr(addr),
        .ubus_size(size), .ubus_read(bus_rd), .ubus_write(bus_wr), .ubus_bip(bip),
        .ubus_data(d_a1), .ubus_wait(w_a1), .ubus_error(e_a1));
    ubus_slave_memory #(.BASE_ADDR(16'h0100), .DEPTH(256), .WAIT_STATES(2)) u_b1 (
        .ubus_clock(clk), .ubus_reset(rst), .ubus_start(st1), .ubus_addr(addr),
        .ubus_size(size), .ubus_read(bus_rd), .ubus_write(bus_wr), .ubus_bip(bip),
        .ubus_data(d_b1), .ubus_wait(w_b1), .ubus_error(e_b1));

    // driven = both copies agree; value is then taken from either copy
    wire       pw_a = tgt ? w_a1 : w_a0;
    wire       pw_b = tgt ? w_b1 : w_b0;
    wire       pe_a = tgt ? e_a1 : e_a0;
    wire       pe_b = tgt ? e_b1 : e_b0;
    wire [7:0] pd_a = tgt ? d_a1 : d_a0;
    wire [7:0] pd_b = tgt ? d_b1 : d_b0;
    wire       w_en = (pw_a == pw_b);
    wire       e_en = (pe_a == pe_b);
    wire       d_en = (pd_a == pd_b);
    wire       w_val = pw_a;
    wire       e_val = pe_a;
    wire [7:0] d_val = pd_a;

    typedef struct {
        bit          tgt;
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [1:0]  size;
        int          nbeats;
        logic [7:0]  dat;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  sz = 1 << v.size;
        int  ws = v.tgt ? 2 : 0;
        int  off = int'(v.addr) - 'h100;
        int  done = 0, ecyc = 0, eerr = 0, ewait = 0;
        int  cyc = 0, nerr = 0, nwait = 0, viol = 0, beat = 0;
        bit  legal;
        logic [7:0] e;
        legal = (v.rd || v.wr) && v.addr >= 16'h0100 && v.addr <= 16'h01FF;
        if (legal && int'(v.addr) + sz - 1 > 'h1FF) begin
            ecyc = 1;
            eerr = 1;
        end else if (legal) begin
            done  = (v.nbeats < sz) ? v.nbeats : sz;
            eerr  = (v.nbeats > sz) ? 1 : 0;
            ecyc  = done * (ws + 1) + eerr;
            ewait = done * ws;
        end
        for (int i = 0; i < done; i++) begin
            if (v.rd) exp_q.push_back(mdl[v.tgt][off + i]);
            else      mdl[v.tgt][off + i] = v.dat + 8'(i);
        end

        tgt = v.tgt;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bus_rd = v.rd; bus_wr = v.wr; addr = v.addr; size = v.size;
        tb_drv = v.wr; tb_dat = v.dat; bip = 1'b1;
        @(posedge clk); #1;
        bus_rd = 1'b0; bus_wr = 1'b0;
        while (cyc < 40) begin
            bip    = (beat < v.nbeats - 1);
            tb_dat = v.dat + 8'(beat);
            @(negedge clk);
            if (!w_en) break;
            cyc++;
            if (e_en != w_en) viol++;
            if (e_val) begin
                nerr++;
                if (v.rd && d_en) viol++;
            end else if (w_val) begin
                nwait++;
                if (v.rd && d_en) viol++;
            end else begin
                if (v.rd) begin
                    if (!d_en) viol++;
                    if (exp_q.size() == 0) begin
                        chk($sformatf("v%0d_sb_underflow", idx), 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("v%0d_rdata_b%0d", idx, beat), int'(d_val), int'(e));
                    end
                end
                beat++;
            end
            @(posedge clk); #1;
        end
        tb_drv = 1'b0; bip = 1'b0;
        chk($sformatf("v%0d_cycles", idx), cyc, ecyc);
        chk($sformatf("v%0d_error_cycles", idx), nerr, eerr);
        chk($sformatf("v%0d_wait_cycles", idx), nwait, ewait);
        chk($sformatf("v%0d_drive_violations", idx), viol, 0);
        if (v.rd) chk($sformatf("v%0d_sb_leftover", idx), exp_q.size(), 0);
        exp_q.delete();
    endtask

    // 4-beat burst at 16'h0140 on the zero-wait slave, reset while the third beat is in flight
    task automatic mid_reset(input bit rd);
        tgt = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bus_rd = rd; bus_wr = !rd; addr = 16'h0140; size = 2'd2;
        bip = 1'b1; tb_drv = !rd; tb_dat = 8'h60;
        @(posedge clk); #1;
        bus_rd = 1'b0; bus_wr = 1'b0;
        @(posedge clk); #1;
        tb_dat = 8'h61;
        @(posedge clk); #1;
        tb_dat = 8'h62;
        @(negedge clk);
        chk($sformatf("rst%0d_pre_wait_driven", rd), int'(w_en), 1);
        chk($sformatf("rst%0d_pre_wait_value", rd), int'(w_val), 0);
        if (rd) chk("rst1_pre_data_driven", int'(d_en), 1);
        #2;
        rst = 1'b1; tb_drv = 1'b0; bip = 1'b0;
        #1;
        chk($sformatf("rst%0d_wait_released", rd), int'(w_en), 0);
        chk($sformatf("rst%0d_error_released", rd), int'(e_en), 0);
        chk($sformatf("rst%0d_data_released", rd), int'(d_en), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        if (!rd) begin
            mdl[0][8'h40] = 8'h60;
            mdl[0][8'h41] = 8'h61;
        end
    endtask

    vec_t vecs [14];
    vec_t post;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h0104, 2'd0, 1, 8'hA5};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0104, 2'd0, 1, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0110, 2'd2, 4, 8'hC0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0110, 2'd2, 4, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h01FE, 2'd1, 2, 8'h11};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h01FE, 2'd2, 4, 8'h99};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h01FE, 2'd1, 2, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0300, 2'd0, 1, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0104, 2'd0, 1, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0122, 2'd0, 1, 8'h55};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h0120, 2'd1, 3, 8'h40};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 16'h0120, 2'd2, 3, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h00FF, 2'd0, 1, 8'h00};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h01FF, 2'd0, 1, 8'h00};

        rst = 1'b1;
        #7;
        chk("reset_wait_released", int'(w_en), 0);
        chk("reset_error_released", int'(e_en), 0);
        chk("reset_data_released", int'(d_en), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        mid_reset(1'b0);
        mid_reset(1'b1);
        post = '{1'b0, 1'b1, 1'b0, 16'h0140, 2'd1, 2, 8'h00};
        run_vec(20, post);
        run_vec(21, vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
